// File: rtl/alu_issue.sv
// Execute-stage issuer: hands one request at a time to the ALU and returns the result.
// Optional ALU_ISSUE_DIVZERO_EN rejects divide-by-zero requests without issuing them.
module alu_issue #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [7:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic [7:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic         alu_cf,
  input  logic [W-1:0] alu_acc,
  input  logic [W-1:0] alu_c,
  input  logic         alu_c_flag,
  input  logic         alu_z_flag,
  input  logic         alu_o_flag,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_acc,
  output logic [W-1:0] rsp_hi,
  output logic         rsp_cf,
  output logic         rsp_zf,
  output logic         rsp_of,
  output logic         rsp_err,
  output logic         cf_q
);

  typedef enum logic [1:0] {StIdle, StExec, StCapt, StResp} state_t;

  state_t       state_q, state_d;
  logic [7:0]   op_q;
  logic [W-1:0] a_q, b_q;
  logic [W-1:0] rsp_acc_q, rsp_hi_q;
  logic         rsp_cf_q, rsp_zf_q, rsp_of_q, rsp_err_q;

  logic accept, op_legal, div_zero, issue, cf_upd, hi_sel;

  always_comb begin
    op_legal = (req_op != 8'h00) && (req_op <= 8'h11);
    div_zero = 1'b0;
`ifdef ALU_ISSUE_DIVZERO_EN
    div_zero = ((req_op == 8'h07) && (req_b[7:0] == 8'h00)) ||
               ((req_op == 8'h08) && (req_b == '0));
`endif
    issue  = op_legal && !div_zero;
    accept = (state_q == StIdle) && req_valid;
    cf_upd = (op_q >= 8'h01 && op_q <= 8'h04) || (op_q == 8'h09);
    hi_sel = (op_q == 8'h06) || (op_q == 8'h08);

    state_d = state_q;
    case (state_q)
      StIdle: if (req_valid) state_d = issue ? StExec : StResp;
      StExec: state_d = StCapt;
      StCapt: state_d = StResp;
      StResp: if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cf_q      <= 1'b0;
      rsp_acc_q <= '0;
      rsp_hi_q  <= '0;
      rsp_cf_q  <= 1'b0;
      rsp_zf_q  <= 1'b0;
      rsp_of_q  <= 1'b0;
      rsp_err_q <= 1'b0;
    end else if (accept) begin
      op_q <= req_op;
      if (issue) begin
        // Operands only move when the ALU will actually see them.
        a_q <= req_a;
        b_q <= req_b;
      end else begin
        rsp_acc_q <= div_zero ? {W{1'b1}} : '0;
        rsp_hi_q  <= div_zero ? {W{1'b1}} : '0;
        rsp_cf_q  <= cf_q;
        rsp_zf_q  <= 1'b0;
        rsp_of_q  <= 1'b0;
        rsp_err_q <= 1'b1;
      end
    end else if (state_q == StCapt) begin
      rsp_acc_q <= alu_acc;
      rsp_hi_q  <= hi_sel ? alu_c : '0;
      rsp_cf_q  <= alu_c_flag;
      rsp_zf_q  <= alu_z_flag;
      rsp_of_q  <= alu_o_flag;
      rsp_err_q <= 1'b0;
      if (cf_upd) cf_q <= alu_c_flag;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign alu_op    = (state_q == StExec) ? op_q : 8'h00;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_cf    = cf_q;
  assign rsp_acc   = rsp_acc_q;
  assign rsp_hi    = rsp_hi_q;
  assign rsp_cf    = rsp_cf_q;
  assign rsp_zf    = rsp_zf_q;
  assign rsp_of    = rsp_of_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: behavioural ALU stub plus a transaction-level reference model.
module tb_alu_issue;

  typedef struct packed {
    logic        cf;
    logic        zf;
    logic        of;
    logic [15:0] hi;
    logic [15:0] acc;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_op = 8'h00;
  logic [15:0] req_a = '0, req_b = '0;
  logic [7:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_acc, alu_c;
  logic        alu_cf, alu_c_flag, alu_z_flag, alu_o_flag;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_acc, rsp_hi;
  logic        rsp_cf, rsp_zf, rsp_of, rsp_err, cf_q;

  int checks = 0;
  int failures = 0;
  int issued_cnt = 0;
  logic [7:0] last_op = 8'h00;
  res_t stub_r = '0;
  logic cf_m = 1'b0;

  alu_issue #(.W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cf(alu_cf),
    .alu_acc(alu_acc), .alu_c(alu_c),
    .alu_c_flag(alu_c_flag), .alu_z_flag(alu_z_flag), .alu_o_flag(alu_o_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_acc(rsp_acc), .rsp_hi(rsp_hi),
    .rsp_cf(rsp_cf), .rsp_zf(rsp_zf), .rsp_of(rsp_of), .rsp_err(rsp_err),
    .cf_q(cf_q)
  );

  always #5 clk = ~clk;

  // Arithmetic meaning of each ALU opcode, written directly from the op semantics.
  function automatic res_t ref_alu(input logic [7:0] op, input logic [15:0] a, b,
                                   input logic cf);
    res_t r;
    logic [16:0] s;
    logic [31:0] p;
    r = '0;
    s = '0;
    case (op)
      8'h01: s = {1'b0, a} + {1'b0, b};
      8'h02: s = {1'b0, a} + {1'b0, b} + 17'(cf);
      8'h03: s = {1'b0, a} - {1'b0, b};
      8'h04: s = {1'b0, a} - {1'b0, b} - 17'(cf);
      8'h09: s = {1'b0, b} - {1'b0, a};
      default: s = '0;
    endcase
    case (op)
      8'h01, 8'h02, 8'h03, 8'h04, 8'h09: begin
        r.acc = s[15:0]; r.cf = s[16]; r.hi = ~s[15:0]; r.of = s[15] ^ a[15];
      end
      8'h06: begin
        p = 32'(a) * 32'(b);
        r.acc = p[15:0]; r.hi = p[31:16]; r.cf = |p[31:16];
      end
      8'h07: begin
        if (b[7:0] == 8'h00) begin r.acc = 16'hFFFF; r.hi = 16'hFFFF; end
        else begin r.acc = a / {8'h00, b[7:0]}; r.hi = a % {8'h00, b[7:0]}; end
      end
      8'h08: begin
        if (b == 16'h0000) begin r.acc = 16'hFFFF; r.hi = 16'hFFFF; end
        else begin r.acc = a / b; r.hi = a % b; end
      end
      default: begin
        case (op)
          8'h05: r.acc = a & b;
          8'h0A: r.acc = a | b;
          8'h0B: r.acc = a ^ b;
          8'h0C: r.acc = ~a;
          8'h0D: r.acc = a << b[3:0];
          8'h0E: r.acc = a >> b[3:0];
          8'h0F: r.acc = a + 16'h1;
          8'h10: r.acc = a - 16'h1;
          default: r.acc = b;
        endcase
        r.hi = a & b;
        r.cf = ^r.acc;
        r.of = r.acc[15];
      end
    endcase
    r.zf = (r.acc == 16'h0000);
    return r;
  endfunction

  // Registered ALU stand-in: holds its outputs when op is 0.
  always @(posedge clk) begin
    if (alu_op != 8'h00) begin
      stub_r     <= ref_alu(alu_op, alu_a, alu_b, alu_cf);
      issued_cnt <= issued_cnt + 1;
      last_op    <= alu_op;
    end
  end
  assign alu_acc    = stub_r.acc;
  assign alu_c      = stub_r.hi;
  assign alu_c_flag = stub_r.cf;
  assign alu_z_flag = stub_r.zf;
  assign alu_o_flag = stub_r.of;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] op, input logic [15:0] a, b,
                        input int delay, input logic early);
    res_t r;
    logic legal, dz, issue, cf_after;
    logic [15:0] e_acc, e_hi;
    logic [3:0] e_flags;
    logic [15:0] h_acc;
    int base, lat, n;
    legal = (op != 8'h00) && (op <= 8'h11);
    dz = 1'b0;
`ifdef ALU_ISSUE_DIVZERO_EN
    dz = ((op == 8'h07) && (b[7:0] == 8'h00)) || ((op == 8'h08) && (b == 16'h0000));
`endif
    issue = legal && !dz;
    cf_after = cf_m;
    if (issue) begin
      r = ref_alu(op, a, b, cf_m);
      e_acc = r.acc;
      e_hi = (op == 8'h06 || op == 8'h08) ? r.hi : 16'h0000;
      e_flags = {r.cf, r.zf, r.of, 1'b0};
      if ((op >= 8'h01 && op <= 8'h04) || op == 8'h09) cf_after = r.cf;
    end else begin
      e_acc = dz ? 16'hFFFF : 16'h0000;
      e_hi = e_acc;
      e_flags = {cf_m, 1'b0, 1'b0, 1'b1};
    end

    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    chk("idle_alu_op", 32'(alu_op), 32'd0);
    rsp_ready = early;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    base = issued_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      chk("busy_req_ready", 32'(req_ready), 32'd0);
      if (alu_op != 8'h00) chk("exec_alu_cf", 32'(alu_cf), 32'(cf_m));
      @(negedge clk);
      lat++;
    end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_latency", 32'(lat), issue ? 32'd3 : 32'd1);
    chk("alu_issues", 32'(issued_cnt - base), issue ? 32'd1 : 32'd0);
    if (issue) chk("alu_issued_op", 32'(last_op), 32'(op));
    chk("rsp_acc", 32'(rsp_acc), 32'(e_acc));
    chk("rsp_hi", 32'(rsp_hi), 32'(e_hi));
    chk("rsp_cf_zf_of_err", 32'({rsp_cf, rsp_zf, rsp_of, rsp_err}), 32'(e_flags));
    chk("cf_q", 32'(cf_q), 32'(cf_after));
    if (!early) begin
      h_acc = rsp_acc;
      for (int i = 0; i < delay; i++) begin
        @(negedge clk);
        chk("hold_valid", 32'(rsp_valid), 32'd1);
        chk("hold_acc", 32'(rsp_acc), 32'(h_acc));
        chk("hold_req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_req_ready", 32'(req_ready), 32'd1);
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    cf_m = cf_after;
  endtask

  initial begin
    logic [7:0] op;
    logic [15:0] a, b;
    #2 rst = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alu", {alu_op, 8'h00, alu_a | alu_b}, 32'd0);
    chk("rst_cf", 32'({cf_q, alu_cf}), 32'd0);
    chk("rst_rsp", 32'({rsp_acc, rsp_hi} | {31'd0, rsp_cf | rsp_zf | rsp_of | rsp_err}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(8'h01, 16'h0003, 16'h0004, 1, 1'b0);
    run_op(8'h01, 16'h8000, 16'h8000, 0, 1'b0);
    chk("carry_set", 32'(cf_q), 32'd1);
    run_op(8'h02, 16'h0001, 16'h0001, 0, 1'b0);
    run_op(8'h01, 16'h8000, 16'h8000, 0, 1'b0);
    run_op(8'h06, 16'h1234, 16'h0100, 2, 1'b0);
    run_op(8'h20, 16'h5555, 16'hAAAA, 5, 1'b0);
    run_op(8'h00, 16'h1111, 16'h2222, 0, 1'b1);

    // Reset while SUB is in EXEC; cf_q is 1 going in.
    @(negedge clk);
    req_valid = 1'b1; req_op = 8'h03; req_a = 16'h0010; req_b = 16'h0001;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstx_exec_op", 32'(alu_op), 32'h03);
    rst = 1'b1;
    #1;
    chk("rstx_alu_op", 32'(alu_op), 32'd0);
    chk("rstx_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstx_cf_q", 32'(cf_q), 32'd0);
    chk("rstx_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    cf_m = 1'b0;
    run_op(8'h01, 16'h0001, 16'h0001, 0, 1'b0);

    run_op(8'h08, 16'h1234, 16'h0000, 1, 1'b0);
    run_op(8'h07, 16'h4321, 16'h1200, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = 8'($urandom_range(0, 20));
      a = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      run_op(op, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
